// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-keeping datapath.
// Holds the field ranges and widths for seconds, minutes and hours, the
// RUN/SET mode encoding and the priority decoder that picks which field
// the setup controller is adjusting.
package clock_pkg;

  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_SEC  = 2'd1,
    SEL_MIN  = 2'd2,
    SEL_HOUR = 2'd3
  } field_sel_e;

  // When several blink flags are raised at once, seconds win over minutes,
  // which win over hours.
  function automatic field_sel_e select_field(input logic f_sec,
                                              input logic f_min,
                                              input logic f_hour);
    if (f_sec)       return SEL_SEC;
    else if (f_min)  return SEL_MIN;
    else if (f_hour) return SEL_HOUR;
    else             return SEL_NONE;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Wrapping modulo counter, 0..MAX.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (count -> 0)
//   en_up        count up one step (MAX wraps to 0)
//   en_down      count down one step (0 wraps to MAX)
//   cnt          registered count value
//   carry_out    high in the cycle an up-step wraps MAX -> 0
// Both enables together cancel and leave the count unchanged.
module mod_counter #(
  parameter int DATA_W = 6,
  parameter int MAX    = 59
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_up,
  input  logic              en_down,
  output logic [DATA_W-1:0] cnt,
  output logic              carry_out
);

  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX);

  logic [DATA_W-1:0] cnt_d;
  logic [DATA_W-1:0] cnt_q;
  logic              up_only;
  logic              down_only;

  assign up_only   = en_up & ~en_down;
  assign down_only = en_down & ~en_up;

  always_comb begin
    cnt_d = cnt_q;
    if (up_only) begin
      cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
    end else if (down_only) begin
      cnt_d = (cnt_q == '0) ? MAX_V : cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt       = cnt_q;
  assign carry_out = up_only & (cnt_q == MAX_V);

endmodule

// File: rtl/time_field_adjust.sv
// Running time-of-day counter with field-by-field manual adjustment.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   tick_1hz                     advances the time while running
//   blink_tick                   toggles the blink phase while setting
//   blink_sec_day/min_month/hour_year  field-select flags (any set = SET)
//   inc, dec                     adjust the selected field by +/-1
//   sec, min, hour               registered time fields (binary)
//   day_carry                    one-cycle pulse on 23:59:59 -> 00:00:00
//   blank_sec/min/hour           display blank request for the blinking field
module time_field_adjust
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       blink_tick,
  input  logic       blink_sec_day,
  input  logic       blink_min_month,
  input  logic       blink_hour_year,
  input  logic       inc,
  input  logic       dec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       day_carry,
  output logic       blank_sec,
  output logic       blank_min,
  output logic       blank_hour
);

  mode_e      mode;
  field_sel_e sel;
  logic       run;
  logic       adj_ok;

  logic sec_up, sec_dn, min_up, min_dn, hour_up, hour_dn;
  logic sec_carry, min_carry, hour_carry;

  logic phase_d, phase_q;
  logic day_carry_d, day_carry_q;
  logic blank_sec_d, blank_sec_q;
  logic blank_min_d, blank_min_q;
  logic blank_hour_d, blank_hour_q;

  // Mode and field select are pure decodes of the controller's flags.
  always_comb begin
    mode = (blink_sec_day | blink_min_month | blink_hour_year) ? MODE_SET : MODE_RUN;
    sel  = select_field(blink_sec_day, blink_min_month, blink_hour_year);
  end

  assign run    = (mode == MODE_RUN);
  // inc and dec together cancel; only a lone pulse counts as an adjustment.
  assign adj_ok = ~run & (inc ^ dec);

  // While running, carries ripple sec -> min -> hour. While setting, each
  // counter sees only its own inc/dec and carries are ignored, so adjusting
  // one field never disturbs another.
  always_comb begin
    sec_up  = (run & tick_1hz)   | (~run & (sel == SEL_SEC)  & inc);
    sec_dn  =                       ~run & (sel == SEL_SEC)  & dec;
    min_up  = (run & sec_carry)  | (~run & (sel == SEL_MIN)  & inc);
    min_dn  =                       ~run & (sel == SEL_MIN)  & dec;
    hour_up = (run & min_carry)  | (~run & (sel == SEL_HOUR) & inc);
    hour_dn =                       ~run & (sel == SEL_HOUR) & dec;
  end

  mod_counter #(.DATA_W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_up     (sec_up),
    .en_down   (sec_dn),
    .cnt       (sec),
    .carry_out (sec_carry)
  );

  mod_counter #(.DATA_W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_up     (min_up),
    .en_down   (min_dn),
    .cnt       (min),
    .carry_out (min_carry)
  );

  mod_counter #(.DATA_W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_up     (hour_up),
    .en_down   (hour_dn),
    .cnt       (hour),
    .carry_out (hour_carry)
  );

  // An accepted adjustment forces the phase to 0 so the new value is shown
  // at once; this also wins over a coincident blink_tick. Blanking is driven
  // from the next phase so it appears one cycle after the causing pulse.
  always_comb begin
    phase_d = phase_q;
    if (run)             phase_d = 1'b0;
    else if (adj_ok)     phase_d = 1'b0;
    else if (blink_tick) phase_d = ~phase_q;

    day_carry_d  = run & hour_carry;
    blank_sec_d  = (sel == SEL_SEC)  & phase_d;
    blank_min_d  = (sel == SEL_MIN)  & phase_d;
    blank_hour_d = (sel == SEL_HOUR) & phase_d;
  end

  // Control / status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= 1'b0;
      day_carry_q  <= 1'b0;
      blank_sec_q  <= 1'b0;
      blank_min_q  <= 1'b0;
      blank_hour_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      day_carry_q  <= day_carry_d;
      blank_sec_q  <= blank_sec_d;
      blank_min_q  <= blank_min_d;
      blank_hour_q <= blank_hour_d;
    end
  end

  assign day_carry  = day_carry_q;
  assign blank_sec  = blank_sec_q;
  assign blank_min  = blank_min_q;
  assign blank_hour = blank_hour_q;

endmodule

// File: tb/tb_time_field_adjust.sv
module tb_time_field_adjust;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, blink_tick;
  logic       blink_sec_day, blink_min_month, blink_hour_year;
  logic       inc, dec;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       day_carry, blank_sec, blank_min, blank_hour;

  int checks = 0;
  int errors = 0;

  time_field_adjust dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick_1hz        (tick_1hz),
    .blink_tick      (blink_tick),
    .blink_sec_day   (blink_sec_day),
    .blink_min_month (blink_min_month),
    .blink_hour_year (blink_hour_year),
    .inc             (inc),
    .dec             (dec),
    .sec             (sec),
    .min             (min),
    .hour            (hour),
    .day_carry       (day_carry),
    .blank_sec       (blank_sec),
    .blank_min       (blank_min),
    .blank_hour      (blank_hour)
  );

  always #5 clk = ~clk;

  // flg = {sec_flag, min_flag, hour_flag}; e_blank = {sec, min, hour}
  typedef struct {
    logic [2:0] flg;
    logic       tick;
    logic       blink;
    logic       inc;
    logic       dec;
    int         e_sec;
    int         e_min;
    int         e_hour;
    logic       e_dc;
    logic [2:0] e_blank;
  } vec_t;

  vec_t vq[$];

  task automatic cmp(input string nm, input int es, input int em, input int eh,
                     input logic edc, input logic [2:0] eb);
    checks++;
    if (int'(sec) != es || int'(min) != em || int'(hour) != eh ||
        day_carry !== edc || {blank_sec, blank_min, blank_hour} !== eb) begin
      errors++;
      $display("FAIL %s: got %0d:%0d:%0d dc=%b blank=%b, want %0d:%0d:%0d dc=%b blank=%b",
               nm, hour, min, sec, day_carry, {blank_sec, blank_min, blank_hour},
               eh, em, es, edc, eb);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge sample them, return 1 ns
  // after the edge with the single-cycle pulses already released.
  task automatic step(input logic [2:0] flg, input logic tk, input logic bl,
                      input logic in, input logic de);
    @(negedge clk);
    {blink_sec_day, blink_min_month, blink_hour_year} = flg;
    tick_1hz = tk; blink_tick = bl; inc = in; dec = de;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; blink_tick = 1'b0; inc = 1'b0; dec = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: plain arithmetic on field values / total seconds.
  int ms, mm, mh, mphase;
  logic mdc;

  task automatic model_step(input logic [2:0] flg, input logic tk, input logic bl,
                            input logic in, input logic de);
    int t;
    int which;
    mdc = 1'b0;
    if (flg == 3'b000) begin
      mphase = 0;
      if (tk) begin
        t = mh * 3600 + mm * 60 + ms + 1;
        if (t == 86400) begin t = 0; mdc = 1'b1; end
        mh = t / 3600; mm = (t / 60) % 60; ms = t % 60;
      end
    end else begin
      which = flg[2] ? 0 : (flg[1] ? 1 : 2);
      if (in != de) begin
        t = in ? 1 : -1;
        case (which)
          0: ms = (ms + t + 60) % 60;
          1: mm = (mm + t + 60) % 60;
          default: mh = (mh + t + 24) % 24;
        endcase
        mphase = 0;
      end else if (bl) begin
        mphase = 1 - mphase;
      end
    end
  endtask

  function automatic logic [2:0] model_blank(input logic [2:0] flg);
    if (mphase == 0 || flg == 3'b000) return 3'b000;
    if (flg[2]) return 3'b100;
    if (flg[1]) return 3'b010;
    return 3'b001;
  endfunction

  initial begin
    logic [2:0] rf;
    logic rt, rb, ri, rd;

    rst_n = 1'b0;
    tick_1hz = 1'b0; blink_tick = 1'b0; inc = 1'b0; dec = 1'b0;
    {blink_sec_day, blink_min_month, blink_hour_year} = 3'b000;

    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state", 0, 0, 0, 1'b0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    //            flg    tk bl in de  sec min hr dc blank
    vq.push_back('{3'b001, 0, 0, 0, 1,  0,  0, 23, 0, 3'b000}); // hour 0 -> 23
    vq.push_back('{3'b010, 0, 0, 0, 1,  0, 59, 23, 0, 3'b000});
    vq.push_back('{3'b100, 0, 0, 0, 1, 59, 59, 23, 0, 3'b000});
    vq.push_back('{3'b100, 0, 0, 0, 1, 58, 59, 23, 0, 3'b000});
    vq.push_back('{3'b000, 0, 0, 0, 0, 58, 59, 23, 0, 3'b000});
    vq.push_back('{3'b000, 1, 0, 0, 0, 59, 59, 23, 0, 3'b000}); // 23:59:59
    vq.push_back('{3'b000, 1, 0, 0, 0,  0,  0,  0, 1, 3'b000}); // day rollover
    vq.push_back('{3'b000, 0, 0, 0, 0,  0,  0,  0, 0, 3'b000}); // carry one cycle
    vq.push_back('{3'b010, 0, 0, 0, 1,  0, 59,  0, 0, 3'b000});
    vq.push_back('{3'b010, 0, 0, 1, 0,  0,  0,  0, 0, 3'b000}); // 59 -> 0, no carry
    vq.push_back('{3'b010, 0, 0, 0, 1,  0, 59,  0, 0, 3'b000});
    vq.push_back('{3'b001, 0, 0, 0, 1,  0, 59, 23, 0, 3'b000}); // hour 0 -> 23
    vq.push_back('{3'b001, 1, 0, 0, 0,  0, 59, 23, 0, 3'b000}); // tick frozen
    vq.push_back('{3'b100, 0, 1, 0, 0,  0, 59, 23, 0, 3'b100});
    vq.push_back('{3'b100, 0, 1, 0, 0,  0, 59, 23, 0, 3'b000});
    vq.push_back('{3'b100, 0, 1, 0, 0,  0, 59, 23, 0, 3'b100});
    vq.push_back('{3'b100, 0, 1, 0, 0,  0, 59, 23, 0, 3'b000});
    vq.push_back('{3'b100, 0, 1, 0, 0,  0, 59, 23, 0, 3'b100});
    vq.push_back('{3'b100, 0, 0, 1, 0,  1, 59, 23, 0, 3'b000}); // inc shows value
    vq.push_back('{3'b100, 0, 1, 0, 0,  1, 59, 23, 0, 3'b100});
    vq.push_back('{3'b100, 0, 1, 1, 0,  2, 59, 23, 0, 3'b000}); // blink+inc -> 0
    vq.push_back('{3'b101, 0, 0, 1, 0,  3, 59, 23, 0, 3'b000}); // sec wins
    vq.push_back('{3'b101, 0, 0, 1, 1,  3, 59, 23, 0, 3'b000}); // inc+dec cancel
    vq.push_back('{3'b101, 0, 1, 0, 0,  3, 59, 23, 0, 3'b100}); // only sec blanks
    vq.push_back('{3'b000, 0, 0, 0, 0,  3, 59, 23, 0, 3'b000});
    vq.push_back('{3'b000, 1, 0, 0, 0,  4, 59, 23, 0, 3'b000}); // resumes counting
    vq.push_back('{3'b000, 0, 0, 1, 0,  4, 59, 23, 0, 3'b000}); // RUN ignores inc
    vq.push_back('{3'b000, 0, 0, 0, 1,  4, 59, 23, 0, 3'b000}); // RUN ignores dec
    vq.push_back('{3'b010, 0, 1, 0, 0,  4, 59, 23, 0, 3'b010});
    vq.push_back('{3'b001, 0, 1, 0, 0,  4, 59, 23, 0, 3'b000});
    vq.push_back('{3'b001, 0, 1, 0, 0,  4, 59, 23, 0, 3'b001});
    vq.push_back('{3'b000, 0, 1, 0, 0,  4, 59, 23, 0, 3'b000}); // RUN: no blink

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].flg, vq[i].tick, vq[i].blink, vq[i].inc, vq[i].dec);
      cmp($sformatf("vec%0d", i), vq[i].e_sec, vq[i].e_min, vq[i].e_hour,
          vq[i].e_dc, vq[i].e_blank);
    end

    // Adjust seconds to 30, raise blank, then reset asynchronously.
    for (int i = 0; i < 26; i++) step(3'b100, 0, 0, 1, 0);
    cmp("sec_to_30", 30, 59, 23, 1'b0, 3'b000);
    step(3'b100, 0, 1, 0, 0);
    cmp("blank_before_rst", 30, 59, 23, 1'b0, 3'b100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst", 0, 0, 0, 1'b0, 3'b000);
    @(negedge clk);
    // Pending inc while in reset must be discarded.
    inc = 1'b1;
    @(posedge clk);
    #1;
    inc = 1'b0;
    cmp("rst_holds", 0, 0, 0, 1'b0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    // Phase was cleared, so the first blink after reset blanks again.
    step(3'b100, 0, 1, 0, 0);
    cmp("phase_after_rst", 0, 0, 0, 1'b0, 3'b100);

    // Randomized run against the reference model.
    {blink_sec_day, blink_min_month, blink_hour_year} = 3'b000;
    do_reset();
    ms = 0; mm = 0; mh = 0; mphase = 0; mdc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rf = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      rt = ($urandom_range(0, 9) < 4);
      rb = ($urandom_range(0, 9) < 2);
      ri = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 3) == 0);
      step(rf, rt, rb, ri, rd);
      model_step(rf, rt, rb, ri, rd);
      cmp($sformatf("rand%0d", i), ms, mm, mh, mdc, model_blank(rf));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
